rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//   N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes and round-robin arbitration.
//   Next generation of the combinational n:1 mux: the select is generated internally, and the winning
//   beat is registered so the output holds stable under back-pressure.
//   Sits between multiple producers and a single shared consumer (bus/port merge point).
// PARAMETERS
//   N      4  number of input channels (N >= 2)
//   WIDTH  8  data width per channel
//   SEL_W  $clog2(N)  localparam; width of channel index
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous, active-low reset
//   in_data    in   N*WIDTH  concatenated inputs; channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   in   N        per-channel valid
//   in_ready   out  N        per-channel ready (one-hot or zero)
//   out_data   out  WIDTH    registered winning data
//   out_sel    out  SEL_W    channel index of out_data
//   out_valid  out  1        output beat valid
//   out_ready  in   1        consumer accepts beat
// BEHAVIOUR
//   Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, last_grant=N-1, in_ready=0.
//   load = ~out_valid | out_ready (output register empty or draining this cycle).
//   Arbiter (combinational): search channels last_grant+1 .. last_grant+N (mod N); first with in_valid=1 wins.
//   in_ready[g] = load & in_valid[g] for winner g; all other bits 0. Never more than one bit set.
//   Transfer on input i: in_valid[i] & in_ready[i]. Next edge: out_data<=in_data[g], out_sel<=g,
//     out_valid<=1, last_grant<=g.
//   If load=1 and no in_valid: out_valid<=0; out_data/out_sel hold last values.
//   If out_valid=1 and out_ready=0: out_data, out_sel, out_valid, last_grant all hold; in_ready=0.
//   Latency: 1 cycle input accept -> out_valid. Throughput: 1 beat/cycle with out_ready held high.
//   Fairness: a continuously asserting channel waits at most N-1 grants.
//   Wrap-around: last_grant=N-1 -> search starts at channel 0.
//   Simultaneous drain and load in one cycle: new beat replaces old, no bubble.
//   in_valid dropped without acceptance: no state change (producers must not retract; not checked).
//   Reset mid-transfer: registered beat discarded, pointer returns to N-1.
// CONFIGURATION
//   RR_ARB_MUX_FORCE_SEL_EN defined: adds ports force_en (in,1) and force_sel (in,SEL_W).
//     With force_en=1, the winner is force_sel if in_valid[force_sel]=1, else no grant. last_grant is
//     NOT updated by forced transfers. force_sel >= N: no grant.
//   Not defined: ports absent; pure round-robin as above.
// TESTING (N=4, WIDTH=8)
//   Reset: rst_n=0 mid-beat -> out_valid=0, out_data=0x00, out_sel=0 immediately (async).
//   in_valid=4'b1111, data ch0..3=0x10,0x21,0x32,0x43, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles, out_valid=1 each.
//   in_valid=4'b0101, out_ready=1 -> grants alternate ch0/ch2; out_data 0x10,0x32,0x10...
//   Beat 0x21 on ch1 with out_ready=0 for 3 cycles -> out_data=0x21, out_sel=1 stable; in_ready=0; released on out_ready=1.
//   last_grant=3, only ch3 valid -> ch3 granted again (wrap); then ch0 asserts -> ch0 wins next.
//   FORCE_SEL_EN: force_en=1, force_sel=2, in_valid=4'b1111 -> out_sel=2 every cycle; force_en=0 -> RR resumes from pre-force pointer.

Source files
------------

// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux
//   Registered N:1 multiplexer with valid/ready handshakes and round-robin
//   arbitration. The winning beat is captured in an output register so it
//   stays stable while the consumer stalls. The input channel selection is
//   generated internally.
//
// Parameters
//   N      number of input channels (N >= 2)
//   WIDTH  data width per channel
//   SEL_W  width of a channel index, $clog2(N)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous assert, active-low reset
//   in_data    concatenated channel data, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered winning data
//   out_sel    channel index of out_data
//   out_valid  output beat valid
//   out_ready  consumer accepts the current output beat
//   force_en   (optional) override arbitration with force_sel
//   force_sel  (optional) channel to grant while force_en is high
//
// Optional feature macro: RR_ARB_MUX_FORCE_SEL_EN
//   When defined, force_en/force_sel are added. A forced grant goes to
//   force_sel only if that channel is valid and in range, and it does not
//   move the round-robin pointer, so arbitration resumes where it left off.
// ---------------------------------------------------------------------------
module rr_arb_mux #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef RR_ARB_MUX_FORCE_SEL_EN
  ,
  input  logic                 force_en,
  input  logic [SEL_W-1:0]     force_sel
`endif
);

  localparam logic [SEL_W:0]   N_EXT     = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(N - 1);

  logic [WIDTH-1:0] chan_data [N];

  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] last_grant_reg;

  logic             load;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W:0]   cand_sum;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_forced;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      // Gated by rst_n so no producer sees a handshake while held in reset.
      assign in_ready[gi]  = rst_n & load & grant_valid & (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // Output register can take a new beat when empty or being drained now.
  assign load = ~out_valid_reg | out_ready;

  // Round-robin search: candidates last_grant+1 .. last_grant+N, wrapped
  // into 0..N-1 by a single conditional subtract (sum never exceeds 2N-1).
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    cand_sum = '0;
    for (int k = 1; k <= N; k++) begin
      cand_sum = {1'b0, last_grant_reg} + (SEL_W+1)'(k);
      if (cand_sum >= N_EXT) begin
        cand_sum = cand_sum - N_EXT;
      end
      if (!rr_valid && in_valid[cand_sum[SEL_W-1:0]]) begin
        rr_valid = 1'b1;
        rr_idx   = cand_sum[SEL_W-1:0];
      end
    end
  end

`ifdef RR_ARB_MUX_FORCE_SEL_EN
  logic force_in_range;
  assign force_in_range = ({1'b0, force_sel} < N_EXT);

  always_comb begin
    grant_valid  = rr_valid;
    grant_idx    = rr_idx;
    grant_forced = 1'b0;
    if (force_en) begin
      grant_valid  = force_in_range && in_valid[force_sel];
      grant_idx    = force_sel;
      grant_forced = 1'b1;
    end
  end
`else
  always_comb begin
    grant_valid  = rr_valid;
    grant_idx    = rr_idx;
    grant_forced = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg   <= '0;
      out_sel_reg    <= '0;
      out_valid_reg  <= 1'b0;
      last_grant_reg <= LAST_CHAN;
    end else if (load) begin
      if (grant_valid) begin
        out_data_reg  <= chan_data[grant_idx];
        out_sel_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
        if (!grant_forced) begin
          last_grant_reg <= grant_idx;
        end
      end else begin
        // Nothing to send: empty the register, keep the stale data/index.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = 2;

  logic               clk;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready;
`ifdef RR_ARB_MUX_FORCE_SEL_EN
  logic               force_en;
  logic [SEL_W-1:0]   force_sel;
`endif

  logic [WIDTH-1:0] tb_data [N];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_lg;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_sel;
  bit         m_force_en;
  int         m_force_sel;

  rr_arb_mux #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = tb_data[i];
  end

  // Winner by the arbitration rule: first valid channel in the order
  // last_grant+1, last_grant+2, ... (mod N); forced selection overrides.
  function automatic int model_winner();
    if (m_force_en) begin
      if (m_force_sel < N && in_valid[m_force_sel]) return m_force_sel;
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_lg + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int w;
    if (!rst_n) return '0;
    w = model_winner();
    if ((!m_valid || out_ready) && w >= 0) return N'(1 << w);
    return '0;
  endfunction

  function automatic void model_reset();
    m_lg    = N - 1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_sel   = 0;
  endfunction

  // One clock edge, advancing the model with the inputs present before it.
  task automatic tick();
    int w;
    bit load;
    w    = model_winner();
    load = !m_valid || out_ready;
    @(posedge clk);
    if (load) begin
      if (w >= 0) begin
        m_data  = tb_data[w];
        m_sel   = w;
        m_valid = 1'b1;
        if (!m_force_en) m_lg = w;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  function automatic void set_fixed_data();
    tb_data[0] = 8'h10;
    tb_data[1] = 8'h21;
    tb_data[2] = 8'h32;
    tb_data[3] = 8'h43;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_fixed_data();
    model_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h sel=%0d, want 0/00/0", out_valid, out_data, out_sel);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, want 0000", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("reset released: in_ready=%b", in_ready);
  endtask

  task automatic test_all_valid();
    int exp_sel [5] = '{0, 1, 2, 3, 0};
    set_fixed_data();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++;
        $display("FAIL all_valid_ready c%0d: in_ready=%b, want %b", c, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== SEL_W'(exp_sel[c]) || out_data !== tb_data[exp_sel[c]]) begin
        errors++;
        $display("FAIL all_valid_out c%0d: valid=%b sel=%0d data=%h, want 1/%0d/%h",
                 c, out_valid, out_sel, out_data, exp_sel[c], tb_data[exp_sel[c]]);
      end
      $display("all_valid c%0d: sel=%0d data=%h", c, out_sel, out_data);
    end
  endtask

  task automatic test_alternate();
    in_valid  = 4'b0101;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++;
        $display("FAIL alt_ready c%0d: in_ready=%b, want %b", c, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_sel !== SEL_W'(m_sel) || out_data !== m_data ||
          (out_sel != 2'd0 && out_sel != 2'd2)) begin
        errors++;
        $display("FAIL alt_out c%0d: valid=%b sel=%0d data=%h, want %b/%0d/%h",
                 c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
      $display("alternate c%0d: sel=%0d data=%h", c, out_sel, out_data);
    end
  endtask

  task automatic test_backpressure();
    // Drain, then load ch1 while the consumer is stalled.
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b, want 0", out_valid);
    end
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    tick();
    in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready c%0d: in_ready=%b, want 0000", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h21 || out_sel !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold c%0d: valid=%b data=%h sel=%0d, want 1/21/1", c, out_valid, out_data, out_sel);
      end
      $display("backpressure hold c%0d: data=%h sel=%0d", c, out_data, out_sel);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== model_ready() || in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b, want 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h32 || out_sel !== 2'd2) begin
      errors++;
      $display("FAIL bp_release: valid=%b data=%h sel=%0d, want 1/32/2", out_valid, out_data, out_sel);
    end
    $display("backpressure release: data=%h sel=%0d", out_data, out_sel);
  endtask

  task automatic test_wrap();
    int exp_sel [3] = '{3, 3, 0};
    logic [N-1:0] vin [3] = '{4'b1000, 4'b1000, 4'b1001};
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = vin[c];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== SEL_W'(exp_sel[c]) || out_sel !== SEL_W'(m_sel)) begin
        errors++;
        $display("FAIL wrap c%0d: valid=%b sel=%0d, want 1/%0d", c, out_valid, out_sel, exp_sel[c]);
      end
      $display("wrap c%0d: in_valid=%b sel=%0d", c, vin[c], out_sel);
    end
  endtask

  task automatic test_reset_mid();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%h sel=%0d rdy=%b, want 0/00/0/0000",
               out_valid, out_data, out_sel, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_ptr: valid=%b sel=%0d, want 1/0", out_valid, out_sel);
    end
    $display("reset mid-beat: first sel after release=%0d", out_sel);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid  = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) tb_data[i] = 8'($urandom);
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++;
        $display("FAIL rand_ready c%0d: in_ready=%b, want %b", c, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid && (out_sel !== SEL_W'(m_sel) || out_data !== m_data))) begin
        errors++;
        $display("FAIL rand_out c%0d: valid=%b sel=%0d data=%h, want %b/%0d/%h",
                 c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
      $display("random c%0d: v=%b rdy=%b out v=%b sel=%0d data=%h",
               c, in_valid, in_ready, out_valid, out_sel, out_data);
    end
  endtask

`ifdef RR_ARB_MUX_FORCE_SEL_EN
  task automatic test_force();
    int pre_lg;
    set_fixed_data();
    in_valid    = 4'b1111;
    out_ready   = 1'b1;
    pre_lg      = m_lg;
    force_en    = 1'b1;
    force_sel   = 2'd2;
    m_force_en  = 1'b1;
    m_force_sel = 2;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h32) begin
        errors++;
        $display("FAIL force c%0d: valid=%b sel=%0d data=%h, want 1/2/32", c, out_valid, out_sel, out_data);
      end
      $display("force c%0d: sel=%0d", c, out_sel);
    end
    force_en   = 1'b0;
    m_force_en = 1'b0;
    tick();
    checks++;
    if (out_sel !== SEL_W'((pre_lg + 1) % N)) begin
      errors++;
      $display("FAIL force_resume: sel=%0d, want %0d", out_sel, (pre_lg + 1) % N);
    end
    $display("force released: sel=%0d", out_sel);
  endtask
`endif

  initial begin
    m_force_en  = 1'b0;
    m_force_sel = 0;
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    force_en  = 1'b0;
    force_sel = '0;
`endif
    test_reset();
    test_all_valid();
    test_alternate();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    test_force();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
